// File: rtl/bread_machine.sv
// Bread machine programme sequencer: knead, rise, knead, rise, bake, bell.
// Moore FSM with a shared phase counter and registered actuator outputs.
module bread_machine #(
    parameter int unsigned KNEAD1_S = 1200,
    parameter int unsigned RISE1_S  = 3600,
    parameter int unsigned KNEAD2_S = 900,
    parameter int unsigned RISE2_S  = 2700,
    parameter int unsigned BAKE_S   = 3600,
    parameter int unsigned BELL_S   = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic rst,
    input  logic clk,
    input  logic start_button,
    output logic bell,
    output logic heating_element,
    output logic paddle_motor
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKnead1 = 3'd1,
        StRise1  = 3'd2,
        StKnead2 = 3'd3,
        StRise2  = 3'd4,
        StBake   = 3'd5,
        StDone   = 3'd6
    } state_e;

    state_e           state_q, state_d, next_phase;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
    logic             timed;
    logic             motor_d, heat_d, bell_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        next_phase = StIdle;
        last_cnt   = '0;
        timed      = 1'b1;
        case (state_q)
            StIdle: begin
                timed = 1'b0;
                cnt_d = '0;
                if (start_button) begin
                    state_d = StKnead1;
                end
            end
            StKnead1: begin last_cnt = CNT_W'(KNEAD1_S - 1); next_phase = StRise1;  end
            StRise1:  begin last_cnt = CNT_W'(RISE1_S - 1);  next_phase = StKnead2; end
            StKnead2: begin last_cnt = CNT_W'(KNEAD2_S - 1); next_phase = StRise2;  end
            StRise2:  begin last_cnt = CNT_W'(RISE2_S - 1);  next_phase = StBake;   end
            StBake:   begin last_cnt = CNT_W'(BAKE_S - 1);   next_phase = StDone;   end
            StDone:   begin last_cnt = CNT_W'(BELL_S - 1);   next_phase = StIdle;   end
            default: begin
                // Unused encoding: fall back to a safe idle.
                timed   = 1'b0;
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (timed && (cnt_q == last_cnt)) begin
            state_d = next_phase;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so the registers track state_q exactly.
    always_comb begin
        motor_d = (state_d == StKnead1) || (state_d == StKnead2);
        heat_d  = (state_d == StBake);
        bell_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            paddle_motor    <= 1'b0;
            heating_element <= 1'b0;
            bell            <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            paddle_motor    <= motor_d;
            heating_element <= heat_d;
            bell            <= bell_d;
        end
    end

endmodule

// File: tb/tb_bread_machine.sv
// Randomized bench for bread_machine: one default-timed and one short-timed instance,
// each checked every cycle against an elapsed-time model of the programme.
module tb_bread_machine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, bell_a, heat_a, motor_a;
    logic rst_b, start_b, bell_b, heat_b, motor_b;

    bread_machine u_dut_a (
        .rst             (rst_a),
        .clk             (clk),
        .start_button    (start_a),
        .bell            (bell_a),
        .heating_element (heat_a),
        .paddle_motor    (motor_a)
    );

    bread_machine #(
        .KNEAD1_S (3),
        .RISE1_S  (3),
        .KNEAD2_S (3),
        .RISE2_S  (3),
        .BAKE_S   (3),
        .BELL_S   (3)
    ) u_dut_b (
        .rst             (rst_b),
        .clk             (clk),
        .start_button    (start_b),
        .bell            (bell_b),
        .heating_element (heat_b),
        .paddle_motor    (motor_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase durations and elapsed cycles since the start edge (1 = first KNEAD1 cycle).
    int unsigned ph [2][6];
    int          e    [2];
    bit          busy [2];

    function automatic int total(input int i);
        int s = 0;
        for (int p = 0; p < 6; p++) s += ph[i][p];
        return s;
    endfunction

    // Returns {bell, heat, motor}.
    function automatic int model_out(input int i);
        int acc = 0;
        int code [6] = '{1, 0, 1, 0, 2, 4};
        if (!busy[i]) return 0;
        for (int p = 0; p < 6; p++) begin
            if (e[i] <= acc + int'(ph[i][p])) return code[p];
            acc += ph[i][p];
        end
        return 0;
    endfunction

    function automatic void model_edge(input int i, input logic r, input logic s);
        if (r) begin
            busy[i] = 1'b0;
        end else if (busy[i]) begin
            e[i]++;
            if (e[i] > total(i)) busy[i] = 1'b0;
        end else if (s) begin
            busy[i] = 1'b1;
            e[i]    = 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(0, rst_a, start_a);
        model_edge(1, rst_b, start_b);
        #1;
        check_eq("out_a", int'({bell_a, heat_a, motor_a}), model_out(0));
        check_eq("out_b", int'({bell_b, heat_b, motor_b}), model_out(1));
        check_eq("excl_a", int'(motor_a & heat_a), 0);
        check_eq("excl_b", int'(motor_b & heat_b), 0);
    endtask

    // Press start randomly only while instance A is kneading (first phase) or baking.
    function automatic logic press_a();
        int k1 = ph[0][0];
        int bk_lo = ph[0][0] + ph[0][1] + ph[0][2] + ph[0][3];
        if (!busy[0]) return 1'b0;
        if (e[0] < k1 || (e[0] >= bk_lo && e[0] < bk_lo + int'(ph[0][4])))
            return ($urandom_range(0, 7) == 0);
        return 1'b0;
    endfunction

    task automatic run_a_with_noise(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            start_a = press_a();
            rst_b   = ($urandom_range(0, 99) == 0);
            start_b = ($urandom_range(0, 3) == 0);
            step();
        end
        start_a = 1'b0;
        rst_b   = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        ph[0] = '{1200, 3600, 900, 2700, 3600, 3};
        ph[1] = '{3, 3, 3, 3, 3, 3};
        busy  = '{1'b0, 1'b0};
        e     = '{0, 0};

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        step();
        step();
        rst_a = 1'b0; rst_b = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // rst wins over start on the same edge.
        rst_b = 1'b1; start_b = 1'b1;
        step();
        check_eq("rst_start_same_edge", int'({bell_b, heat_b, motor_b}), 0);
        rst_b = 1'b0; start_b = 1'b0;
        step();

        // Full default programme with button noise in KNEAD1/BAKE.
        start_a = 1'b1;
        step();
        check_eq("motor_latency", int'(motor_a), 1);
        start_a = 1'b0;
        run_a_with_noise(12010);
        check_eq("a_idle_after_run", int'({bell_a, heat_a, motor_a}), 0);

        // Holding start across the return to IDLE restarts on the next sampled edge.
        start_b = 1'b1;
        for (int k = 0; k < 60; k++) step();
        start_b = 1'b0;

        // Reset mid-bake, then replay from KNEAD1.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 9000 && e[0] != 8500; k++) step();
        check_eq("reached_bake", int'(heat_a), 1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check_eq("rst_mid_bake", int'({bell_a, heat_a, motor_a}), 0);
        step();
        start_a = 1'b1;
        step();
        check_eq("replay_knead1", int'(motor_a), 1);
        start_a = 1'b0;
        run_a_with_noise(12010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
